disp_colour_adapt: RTL
======================

Name: disp_colour_adapt

Overview:
- Parametrised display-output colour stage between the chapter display core and the board TMDS encoder.
- Converts RGB channels from system BPC_IN to board BPC_OUT width for any width pair, using bit replication to expand or truncation/ordered dither to reduce.
- Forces black outside the active area.
- Delays hsync/vsync/de by the same configurable pipeline latency as the colour path.

Parameters:
- BPC_IN, 5, system bits per colour channel (1..12).
- BPC_OUT, 8, board bits per colour channel (1..12).
- LAT, 1, pipeline latency in clock cycles (1..4).

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, reset; synchronous, active-high.
- frame, input, 1, single-cycle start-of-frame pulse; occurs in blanking.
- disp_hsync, input, 1, horizontal sync from display core.
- disp_vsync, input, 1, vertical sync from display core.
- disp_de, input, 1, data enable (active pixel).
- disp_r, input, BPC_IN, red channel.
- disp_g, input, BPC_IN, green channel.
- disp_b, input, BPC_IN, blue channel.
- board_hsync, output, 1, disp_hsync delayed LAT cycles.
- board_vsync, output, 1, disp_vsync delayed LAT cycles.
- board_de, output, 1, disp_de delayed LAT cycles.
- board_r, output, BPC_OUT, converted red.
- board_g, output, BPC_OUT, converted green.
- board_b, output, BPC_OUT, converted blue.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: all outputs 0, every pipeline stage 0, x_par, y_par and frame_cnt all 0. Asserting rst mid-line gives 0 on all outputs from the next edge. After release, the first valid output appears LAT cycles later.
- Latency: every output at cycle n is a function of the inputs (and counter state) sampled at cycle n-LAT. Sync, de and colour stay exactly aligned.
- Blanking: if disp_de was 0 at sampling time, board_r/g/b = 0. Sync and de still pass through.
- Width rules, applied per channel independently:
  - BPC_OUT == BPC_IN: pass-through.
  - BPC_OUT > BPC_IN: the input value is replicated MSB-first until BPC_OUT bits are filled; the top BPC_OUT bits are taken (5->8: abcde -> abcdeabc). All-ones maps to all-ones; 0 maps to 0.
  - BPC_OUT < BPC_IN: D = BPC_IN-BPC_OUT. Without dither, output = input >> D. With dither, see Optional Feature.
- Position counters, updated every cycle regardless of the dither build:
  - x_par toggles on each cycle with disp_de=1; cleared when disp_de=0.
  - y_par toggles on each falling edge of disp_de (line end).
  - frame=1 clears y_par and increments the 2-bit frame_cnt (wraps 3->0). If frame and a de falling edge coincide, frame wins (y_par=0).
- Counter values used for a pixel are those before that cycle's update (the first pixel of a line uses x_par=0).

Optional Feature:
- Macro: DISP_DITHER_EN.
- With the macro defined, and only when BPC_OUT < BPC_IN:
  - xp = x_par ^ frame_cnt[0]; yp = y_par ^ frame_cnt[1].
  - Threshold t from a 2x2 Bayer matrix: (yp,xp) (0,0)->0, (0,1)->2, (1,0)->3, (1,1)->1.
  - offset = (t << D) >> 2.
  - sum = input + offset, saturated to all-ones of BPC_IN bits.
  - output = sum >> D.
- Without the macro: truncation only; the counters may be optimised away. Expansion and pass-through are identical in both builds.

Test Plan:
- BPC_IN=5, BPC_OUT=8, LAT=1, de=1, r=22, g=31, b=0 -> one cycle later board_r=181, board_g=255, board_b=0, board_de=1.
- LAT=3: pulse disp_hsync=1 for 1 cycle with de=0 and r=31 -> board_hsync=1 exactly 3 cycles later; board_r stays 0 throughout.
- BPC_IN=8, BPC_OUT=5, macro off: r=0x84 -> 16; r=0xFF -> 31; r=0x07 -> 0.
- Macro on, BPC_IN=8, BPC_OUT=5, frame_cnt=0, constant r=0x84:
  - Line 0 outputs 16,17,16,17…; line 1 outputs 17,16,17,16….
  - After one frame pulse, line 0 outputs 17,16,….
  - r=0xFF gives 31 everywhere (saturation).
- Frame pulse coinciding with a de falling edge -> the next line uses y_par=0; 4 frame pulses return frame_cnt to 0 (the pattern repeats).
- Assert rst for 1 cycle mid-line with de=1, r=31 -> all outputs 0 on the next edge; the first pixel after release uses x_par=0 and emerges LAT cycles later.

Source files
------------

// File: rtl/disp_colour_adapt.sv
// Display colour stage that adapts RGB width, blanks outside the active area and
// delays sync/de/colour together by LAT clocks. Define DISP_DITHER_EN to use
// 2x2 ordered dither when reducing width.
module disp_colour_adapt #(
   parameter int BPC_IN  = 5,
   parameter int BPC_OUT = 8,
   parameter int LAT     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame,
   input  logic               disp_hsync,
   input  logic               disp_vsync,
   input  logic               disp_de,
   input  logic [BPC_IN-1:0]  disp_r,
   input  logic [BPC_IN-1:0]  disp_g,
   input  logic [BPC_IN-1:0]  disp_b,
   output logic               board_hsync,
   output logic               board_vsync,
   output logic               board_de,
   output logic [BPC_OUT-1:0] board_r,
   output logic [BPC_OUT-1:0] board_g,
   output logic [BPC_OUT-1:0] board_b
);

   localparam int PW = 3 + 3 * BPC_OUT;

   logic       r_de_d;
   logic       r_x_par;
   logic       r_y_par;
   logic [1:0] r_frame_cnt;

   // A frame pulse takes priority over a line-end toggle of y_par.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_de_d      <= 1'b0;
         r_x_par     <= 1'b0;
         r_y_par     <= 1'b0;
         r_frame_cnt <= 2'd0;
      end else begin
         r_de_d  <= disp_de;
         r_x_par <= disp_de & ~r_x_par;
         if (frame) begin
            r_y_par     <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 2'd1;
         end else if (r_de_d && !disp_de) begin
            r_y_par <= ~r_y_par;
         end
      end
   end

   logic [BPC_OUT-1:0] w_r;
   logic [BPC_OUT-1:0] w_g;
   logic [BPC_OUT-1:0] w_b;

   generate
      if (BPC_OUT == BPC_IN) begin : g_pass
         assign w_r = disp_r;
         assign w_g = disp_g;
         assign w_b = disp_b;
         logic w_unused_cnt;
         assign w_unused_cnt = ^{r_x_par, r_y_par, r_frame_cnt};
      end else if (BPC_OUT > BPC_IN) begin : g_expand
         function automatic logic [BPC_OUT-1:0] f_expand(input logic [BPC_IN-1:0] v);
            logic [BPC_OUT-1:0] o;
            o = '0;
            for (int i = 0; i < BPC_OUT; i++) o[BPC_OUT-1-i] = v[BPC_IN-1-(i % BPC_IN)];
            return o;
         endfunction
         assign w_r = f_expand(disp_r);
         assign w_g = f_expand(disp_g);
         assign w_b = f_expand(disp_b);
         logic w_unused_cnt;
         assign w_unused_cnt = ^{r_x_par, r_y_par, r_frame_cnt};
      end else begin : g_reduce
         localparam int D = BPC_IN - BPC_OUT;
`ifdef DISP_DITHER_EN
         logic       w_xp;
         logic       w_yp;
         logic [1:0] w_thr;
         assign w_xp = r_x_par ^ r_frame_cnt[0];
         assign w_yp = r_y_par ^ r_frame_cnt[1];

         always_comb begin
            w_thr = 2'd0;
            case ({w_yp, w_xp})
               2'b00:   w_thr = 2'd0;
               2'b01:   w_thr = 2'd2;
               2'b10:   w_thr = 2'd3;
               default: w_thr = 2'd1;
            endcase
         end

         // One spare bit catches the carry so the sum can saturate.
         function automatic logic [BPC_OUT-1:0] f_dither(input logic [BPC_IN-1:0] v,
                                                         input logic [1:0] t);
            logic [BPC_IN:0] off;
            logic [BPC_IN:0] sum;
            off = ({{(BPC_IN-1){1'b0}}, t} << D) >> 2;
            sum = {1'b0, v} + off;
            if (sum[BPC_IN]) sum = {1'b0, {BPC_IN{1'b1}}};
            return sum[BPC_IN-1 -: BPC_OUT];
         endfunction

         assign w_r = f_dither(disp_r, w_thr);
         assign w_g = f_dither(disp_g, w_thr);
         assign w_b = f_dither(disp_b, w_thr);
`else
         assign w_r = disp_r[BPC_IN-1 -: BPC_OUT];
         assign w_g = disp_g[BPC_IN-1 -: BPC_OUT];
         assign w_b = disp_b[BPC_IN-1 -: BPC_OUT];
         logic w_unused_lsb;
         assign w_unused_lsb = ^{disp_r[D-1:0], disp_g[D-1:0], disp_b[D-1:0],
                                 r_x_par, r_y_par, r_frame_cnt};
`endif
      end
   endgenerate

   logic [PW-1:0] w_stage;
   assign w_stage = {disp_hsync, disp_vsync, disp_de,
                     disp_de ? {w_r, w_g, w_b} : {(3 * BPC_OUT){1'b0}}};

   logic [PW-1:0] r_pipe [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_stage;
         for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign {board_hsync, board_vsync, board_de, board_r, board_g, board_b} = r_pipe[LAT-1];

endmodule
